// File: rtl/mc_isa_pkg.sv
// Shared ISA, ALU-op, select and state definitions for the TSC multi-cycle controller.
package mc_isa_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ALU_LAST = 6'd7;
  localparam logic [5:0] FN_JPR      = 6'd25;
  localparam logic [5:0] FN_JRL      = 6'd26;
  localparam logic [5:0] FN_WWD      = 6'd28;
  localparam logic [5:0] FN_HLT      = 6'd29;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_ORR   = 4'd3;
  localparam logic [3:0] ALU_NOT   = 4'd4;
  localparam logic [3:0] ALU_TCP   = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_LHI   = 4'd8;
  localparam logic [3:0] ALU_BNE   = 4'd9;
  localparam logic [3:0] ALU_BEQ   = 4'd10;
  localparam logic [3:0] ALU_BGZ   = 4'd11;
  localparam logic [3:0] ALU_BLZ   = 4'd12;
  localparam logic [3:0] ALU_PASSA = 4'd13;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_TARGET = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_R2 = 2'b10;

  // JPR/JRL share the JMP/JAL execute states (PCSource then comes from the
  // instruction), which keeps all sixteen states inside a 4-bit encoding.
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_WB_R   = 4'd3,
    S_EX_I   = 4'd4,
    S_WB_I   = 4'd5,
    S_EX_ADR = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_M   = 4'd8,
    S_MEM_WR = 4'd9,
    S_EX_BR  = 4'd10,
    S_EX_J   = 4'd11,
    S_EX_JAL = 4'd12,
    S_WB_L   = 4'd13,
    S_EX_W   = 4'd14,
    S_HALT   = 4'd15
  } state_e;

endpackage

// File: rtl/mc_inst_class.sv
// Combinational opcode/func classifier: ID next-state target and execute-stage ALUOp.
module mc_inst_class
  import mc_isa_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output state_e     id_next,
  output logic [3:0] ex_alu_op,
  output logic       jump_reg
);

  always_comb begin
    id_next   = S_IF;
    ex_alu_op = ALU_ADD;
    jump_reg  = 1'b0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        id_next   = S_EX_BR;
        ex_alu_op = ALU_BNE + opcode;
      end
      OP_ADI: id_next = S_EX_I;
      OP_ORI: begin
        id_next   = S_EX_I;
        ex_alu_op = ALU_ORR;
      end
      OP_LHI: begin
        id_next   = S_EX_I;
        ex_alu_op = ALU_LHI;
      end
      OP_LWD, OP_SWD: id_next = S_EX_ADR;
      OP_JMP: id_next = S_EX_J;
      OP_JAL: begin
        id_next   = S_EX_JAL;
        ex_alu_op = ALU_PASSA;
      end
      OP_RTYPE: begin
        if (func <= FN_ALU_LAST) begin
          id_next   = S_EX_R;
          ex_alu_op = func[3:0];
        end else begin
          case (func)
            FN_JPR: begin
              id_next  = S_EX_J;
              jump_reg = 1'b1;
            end
            FN_JRL: begin
              id_next   = S_EX_JAL;
              ex_alu_op = ALU_PASSA;
              jump_reg  = 1'b1;
            end
            FN_WWD: begin
              id_next   = S_EX_W;
              ex_alu_op = ALU_PASSA;
            end
            FN_HLT:  id_next = S_HALT;
            default: id_next = S_IF;
          endcase
        end
      end
      default: id_next = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit TSC CPU; Moore outputs held at 0 while reset_n is low.
// Optional MC_CTRL_STATE_DBG_EN adds a state_dbg[3:0] output mirroring the state register.
module mc_control_fsm
  import mc_isa_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] inst,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [1:0]           RegDst,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUOp,
  output logic [5:0]           func,
  output logic                 is_halted
`ifdef MC_CTRL_STATE_DBG_EN
  ,
  output logic [3:0]           state_dbg
`endif
);

  state_e     state_q, state_d;
  state_e     cls_next;
  logic [3:0] cls_alu_op;
  logic       cls_jump_reg;
  logic [3:0] opcode;
  logic       unused_inst_bits;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0] pc_source, reg_dst, alu_src_b;
  logic [3:0] alu_op;

  assign opcode           = inst[WORD_SIZE-1 -: 4];
  assign unused_inst_bits = ^inst[WORD_SIZE-5:6];

  mc_inst_class u_class (
    .opcode    (opcode),
    .func      (inst[5:0]),
    .id_next   (cls_next),
    .ex_alu_op (cls_alu_op),
    .jump_reg  (cls_jump_reg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    halted        = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_ONE;
        pc_write  = 1'b1;
        state_d   = S_ID;
      end
      S_ID: begin
        alu_src_b = SRCB_SEXT;
        state_d   = cls_next;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = cls_alu_op;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        state_d   = S_IF;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OP_ADI) ? SRCB_SEXT : SRCB_ZEXT;
        alu_op    = cls_alu_op;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_EX_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        state_d   = (opcode == OP_LWD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_WB_M;
      end
      S_WB_M: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_IF;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = S_IF;
      end
      S_EX_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = cls_alu_op;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        state_d       = S_IF;
      end
      S_EX_J: begin
        pc_write  = 1'b1;
        pc_source = cls_jump_reg ? PCS_REG : PCS_TARGET;
        state_d   = S_IF;
      end
      S_EX_JAL: begin
        pc_write  = 1'b1;
        pc_source = cls_jump_reg ? PCS_REG : PCS_TARGET;
        alu_op    = ALU_PASSA;
        state_d   = S_WB_L;
      end
      S_WB_L: begin
        reg_write = 1'b1;
        reg_dst   = DST_R2;
        state_d   = S_IF;
      end
      S_EX_W: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_PASSA;
        state_d   = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // Async reset forces IF, whose decode would strobe memory; mask everything instead.
  assign PCWrite     = reset_n & pc_write;
  assign PCWriteCond = reset_n & pc_write_cond;
  assign PCSource    = reset_n ? pc_source : 2'b00;
  assign IorD        = reset_n & iord;
  assign MemRead     = reset_n & mem_read;
  assign MemWrite    = reset_n & mem_write;
  assign IRWrite     = reset_n & ir_write;
  assign MemtoReg    = reset_n & mem_to_reg;
  assign RegWrite    = reset_n & reg_write;
  assign RegDst      = reset_n ? reg_dst : 2'b00;
  assign ALUSrcA     = reset_n & alu_src_a;
  assign ALUSrcB     = reset_n ? alu_src_b : 2'b00;
  assign ALUOp       = reset_n ? alu_op : 4'd0;
  assign is_halted   = reset_n & halted;
  assign func        = (opcode == OP_RTYPE) ? inst[5:0] : 6'd0;

`ifdef MC_CTRL_STATE_DBG_EN
  assign state_dbg = reset_n ? state_q : 4'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed instructions push per-cycle expected control words.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [5:0] func;
    logic       is_halted;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] inst;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, ALUSrcA, is_halted;
  logic [1:0]  PCSource, RegDst, ALUSrcB;
  logic [3:0]  ALUOp;
  logic [5:0]  func;
  ctrl_t       got;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          fails   = 0;
  logic [5:0]  cur_func = 6'd0;
  string       cur_name = "RESET";

  always #5 clk = ~clk;

  mc_control_fsm #(.WORD_SIZE(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inst        (inst),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .func        (func),
    .is_halted   (is_halted)
  );

  assign got = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, func, is_halted};

  // args: pcw pcc pcs iord mr mw irw m2r rw dst sa sb op halt
  function automatic ctrl_t mk(input bit pcw, input bit pcc, input bit [1:0] pcs,
                               input bit iord, input bit mr, input bit mw, input bit irw,
                               input bit m2r, input bit rw, input bit [1:0] dst,
                               input bit sa, input bit [1:0] sb, input bit [3:0] op,
                               input bit halt);
    ctrl_t c;
    c = '0;
    c.pc_write = pcw;  c.pc_write_cond = pcc; c.pc_source = pcs;
    c.iord = iord;     c.mem_read = mr;       c.mem_write = mw;
    c.ir_write = irw;  c.mem_to_reg = m2r;    c.reg_write = rw;
    c.reg_dst = dst;   c.alu_src_a = sa;      c.alu_src_b = sb;
    c.alu_op = op;     c.is_halted = halt;
    return c;
  endfunction

  ctrl_t W_ZERO, W_IF, W_ID, W_EXR_ADD, W_EXR_SUB, W_WBR, W_EXI_ORI, W_WBI;
  ctrl_t W_EXADR, W_MEMRD, W_WBM, W_MEMWR, W_EXBR_BEQ, W_EXJAL, W_EXJRL, W_EXJPR;
  ctrl_t W_WBL, W_EXW, W_HALT;

  initial begin
    W_ZERO     = '0;
    W_IF       = mk(1,0,2'd0, 0,1,0,1, 0,0,2'd0, 0,2'd1, 4'd0,  0);
    W_ID       = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 0,2'd2, 4'd0,  0);
    W_EXR_ADD  = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 1,2'd0, 4'd0,  0);
    W_EXR_SUB  = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 1,2'd0, 4'd1,  0);
    W_WBR      = mk(0,0,2'd0, 0,0,0,0, 0,1,2'd1, 0,2'd0, 4'd0,  0);
    W_EXI_ORI  = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 1,2'd3, 4'd3,  0);
    W_WBI      = mk(0,0,2'd0, 0,0,0,0, 0,1,2'd0, 0,2'd0, 4'd0,  0);
    W_EXADR    = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 1,2'd2, 4'd0,  0);
    W_MEMRD    = mk(0,0,2'd0, 1,1,0,0, 0,0,2'd0, 0,2'd0, 4'd0,  0);
    W_WBM      = mk(0,0,2'd0, 0,0,0,0, 1,1,2'd0, 0,2'd0, 4'd0,  0);
    W_MEMWR    = mk(0,0,2'd0, 1,0,1,0, 0,0,2'd0, 0,2'd0, 4'd0,  0);
    W_EXBR_BEQ = mk(0,1,2'd1, 0,0,0,0, 0,0,2'd0, 1,2'd0, 4'd10, 0);
    W_EXJAL    = mk(1,0,2'd2, 0,0,0,0, 0,0,2'd0, 0,2'd0, 4'd13, 0);
    W_EXJRL    = mk(1,0,2'd3, 0,0,0,0, 0,0,2'd0, 0,2'd0, 4'd13, 0);
    W_EXJPR    = mk(1,0,2'd3, 0,0,0,0, 0,0,2'd0, 0,2'd0, 4'd0,  0);
    W_WBL      = mk(0,0,2'd0, 0,0,0,0, 0,1,2'd2, 0,2'd0, 4'd0,  0);
    W_EXW      = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 1,2'd0, 4'd13, 0);
    W_HALT     = mk(0,0,2'd0, 0,0,0,0, 0,0,2'd0, 0,2'd0, 4'd0,  1);
  end

  task automatic push(input ctrl_t c, input string tag);
    exp_t e;
    e.c      = c;
    e.c.func = cur_func;
    e.tag    = {cur_name, "/", tag};
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [15:0] i, input string nm);
    inst     = i;
    cur_name = nm;
    cur_func = (i[15:12] == 4'hF) ? i[5:0] : 6'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with an outstanding expectation is one vector.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (got !== e.c) begin
        fails++;
        $display("FAIL %s: got %h required %h", e.tag, got, e.c);
      end else begin
        $display("ok   %s: %h", e.tag, got);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    inst    = 16'h0000;
    @(posedge clk); #1;
    push(W_ZERO, "rst0");
    step(1);
    push(W_ZERO, "rst1");
    step(1);
    reset_n = 1'b1;

    start(16'hF1C0, "ADD");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXR_ADD, "EX_R"); push(W_WBR, "WB_R");
    step(4);

    start(16'h7106, "LWD");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXADR, "EX_ADR");
    push(W_MEMRD, "MEM_RD"); push(W_WBM, "WB_M");
    step(5);

    start(16'h8106, "SWD");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXADR, "EX_ADR"); push(W_MEMWR, "MEM_WR");
    step(4);

    start(16'h1102, "BEQ");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXBR_BEQ, "EX_BR");
    step(3);

    start(16'hA123, "JAL");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXJAL, "EX_JAL"); push(W_WBL, "WB_L");
    step(4);

    start(16'h5123, "ORI");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXI_ORI, "EX_I"); push(W_WBI, "WB_I");
    step(4);

    start(16'hF1C1, "SUB");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXR_SUB, "EX_R"); push(W_WBR, "WB_R");
    step(4);

    start(16'hF019, "JPR");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXJPR, "EX_J");
    step(3);

    start(16'hF01A, "JRL");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXJRL, "EX_JAL"); push(W_WBL, "WB_L");
    step(4);

    start(16'hB000, "NOPOP");
    push(W_IF, "IF"); push(W_ID, "ID");
    step(2);

    start(16'hF008, "NOPFN");
    push(W_IF, "IF"); push(W_ID, "ID");
    step(2);

    start(16'hF01D, "HLT");
    push(W_IF, "IF"); push(W_ID, "ID");
    for (int k = 0; k < 20; k++) push(W_HALT, $sformatf("HALT%0d", k));
    step(22);

    // Short asynchronous reset pulse between clock edges.
    reset_n = 1'b0;
    #1;
    vectors++;
    if (got !== {20'd0, cur_func, 1'b0}) begin
      fails++;
      $display("FAIL HLT/rst_pulse: got %h required %h", got, {20'd0, cur_func, 1'b0});
    end else begin
      $display("ok   HLT/rst_pulse: %h", got);
    end
    reset_n = 1'b1;

    start(16'hF01C, "WWD");
    push(W_IF, "IF"); push(W_ID, "ID"); push(W_EXW, "EX_W");
    step(3);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      vectors++;
      fails++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
